tank_hit_tracker: RTL and testbench
===================================

// Module: tank_hit_tracker
// PURPOSE
//  Per-round damage bookkeeping for both tanks; sits directly upstream of the game-state FSM.
//  Consumes per-frame bullet/mine collision flags from the collision logic.
//  Produces tank1gaya/tank2gaya death flags (level, held) that trigger the explosion sequence.
//  Also exports health and post-hit invulnerability status to the colour mapper.
// PARAMETERS
//  MAX_HP         3   hit points per tank at round start (1..15)
//  INVULN_FRAMES  30  frames of invulnerability after a non-fatal bullet hit (0 = none)
//  localparam HP_W = $clog2(MAX_HP+1); CNT_W = $clog2(INVULN_FRAMES+1) (min 1)
// PORTS
//  fsm_clock     in   1     frame-rate clock, same clock as the game-state FSM
//  reset_n       in   1     synchronous, active-low reset
//  game_on       in   1     from game-state FSM; high while a round is in play or exploding
//  bullet_hit1   in   1     tank 1 struck by P2 bullet this frame
//  bullet_hit2   in   1     tank 2 struck by P1 bullet this frame
//  mine_hit1     in   1     tank 1 on a mine this frame (instant kill)
//  mine_hit2     in   1     tank 2 on a mine this frame (instant kill)
//  tank1gaya     out  1     tank 1 destroyed; held until next round start
//  tank2gaya     out  1     tank 2 destroyed; held until next round start
//  health1       out  HP_W  tank 1 remaining HP
//  health2       out  HP_W  tank 2 remaining HP
//  invuln1       out  1     tank 1 invulnerable (invuln counter != 0), for sprite blinking
//  invuln2       out  1     tank 2 invulnerable
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state=IDLE, health1/2=MAX_HP, gaya=0, invuln counters=0, game_on_q=0.
//  All outputs are registered; no combinational input->output path.
//  States: IDLE (round not running), ACTIVE (hits processed), OVER (a tank died; damage frozen).
//  Round start = game_on high while registered game_on_q low (rising edge, one cycle):
//   any state -> ACTIVE; health=MAX_HP, gaya=0, counters=0 at that edge; hits that cycle ignored.
//  IDLE: hits ignored; stays until round start.
//  ACTIVE, per tank i, evaluated each edge:
//   mine_hit_i -> health_i=0 regardless of invulnerability.
//   else bullet_hit_i and cnt_i==0 -> health_i-=1 (saturate at 0), cnt_i=INVULN_FRAMES.
//   else bullet_hit_i and cnt_i!=0 -> ignored; cnt_i decrements.
//   else cnt_i>0 -> cnt_i-=1.
//   New health_i==0 -> tankigaya=1 on the same edge as the health update (1-cycle latency from hit).
//   Any gaya set -> ACTIVE->OVER. Both tanks may die on the same edge; both flags set.
//  OVER: all hits ignored; health, gaya frozen; counters cleared to 0. Flags stay high while
//   game_on is high (explosion frames) and after game_on falls (death screen), until next round start.
//  ACTIVE and game_on falls (menu key) -> IDLE; gaya stay 0, health frozen.
//  Reset mid-round overrides everything; the next game_on rising edge starts a clean round.
//  Health arithmetic is unsigned HP_W; never wraps below 0.
// CONFIGURATION
//  SCORE_TRACK_EN defined: extra outputs score1, score2 (4 bits each) = rounds won per player.
//   Incremented on the ACTIVE->OVER edge for the player whose opponent died; a double kill scores
//   neither. Saturates at 9. Cleared only by reset_n, not by round start.
//  SCORE_TRACK_EN undefined: score ports and logic are absent; all other behaviour is unchanged.
// TESTING
//  Reset, then game_on 0->1 -> health1=health2=3, gaya=0, invuln=0, state ACTIVE.
//  bullet_hit1 1 cycle -> next edge health1=2, invuln1=1 for 30 cycles; 2nd hit at +10 cycles ignored.
//  3 bullet_hit1 spaced 31 cycles -> health1=0 and tank1gaya=1 on the 3rd hit's edge; later hit2 ignored.
//  mine_hit2 while invuln2=1 -> health2=0, tank2gaya=1 next edge; held through game_on 1->0->1 until restart clears.
//  bullet_hit1+mine_hit2 same cycle with health1=1 -> both gaya=1 same edge; (SCORE_TRACK_EN) scores unchanged.
//  reset_n=0 mid-round with health1=1 -> all outputs at reset values; hits ignored until next game_on rising edge.

Source files
------------

// File: rtl/tank_hit_tracker.sv
// rtl/tank_hit_tracker.sv - per-round hit points, invulnerability and death flags for both tanks
// Optional SCORE_TRACK_EN macro adds per-player rounds-won counters (score1/score2).
module tank_hit_tracker #(
  parameter int MAX_HP        = 3,
  parameter int INVULN_FRAMES = 30,
  localparam int HP_W  = $clog2(MAX_HP + 1),
  localparam int CNT_W = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1)
) (
  input  logic            fsm_clock,
  input  logic            reset_n,
  input  logic            game_on,
  input  logic            bullet_hit1,
  input  logic            bullet_hit2,
  input  logic            mine_hit1,
  input  logic            mine_hit2,
  output logic            tank1gaya,
  output logic            tank2gaya,
  output logic [HP_W-1:0] health1,
  output logic [HP_W-1:0] health2,
  output logic            invuln1,
  output logic            invuln2
`ifdef SCORE_TRACK_EN
  ,
  output logic [3:0]      score1,
  output logic [3:0]      score2
`endif
);

  typedef enum logic [1:0] {IDLE, ACTIVE, OVER} state_t;

  localparam logic [HP_W-1:0]  HP_FULL  = HP_W'(MAX_HP);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_FRAMES);

  state_t                     state_q, state_d;
  logic                       game_on_q;
  logic [1:0][HP_W-1:0]       hp_q, hp_d;
  logic [1:0][CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]                 gaya_q, gaya_d;
  logic [1:0]                 bullet, mine;
  logic                       round_start;

  assign bullet      = {bullet_hit2, bullet_hit1};
  assign mine        = {mine_hit2, mine_hit1};
  assign round_start = game_on & ~game_on_q;

  always_ff @(posedge fsm_clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      game_on_q <= 1'b0;
      hp_q      <= {2{HP_FULL}};
      cnt_q     <= '0;
      gaya_q    <= '0;
    end else begin
      state_q   <= state_d;
      game_on_q <= game_on;
      hp_q      <= hp_d;
      cnt_q     <= cnt_d;
      gaya_q    <= gaya_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    gaya_d  = gaya_q;
    if (round_start) begin
      state_d = ACTIVE;
      hp_d    = {2{HP_FULL}};
      cnt_d   = '0;
      gaya_d  = '0;
    end else begin
      case (state_q)
        ACTIVE: begin
          if (!game_on) begin
            // Round aborted from the menu: no blinking outside a round.
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            for (int i = 0; i < 2; i++) begin
              if (mine[i]) begin
                hp_d[i] = '0;
              end else if (bullet[i] && cnt_q[i] == '0) begin
                hp_d[i]  = (hp_q[i] == '0) ? '0 : hp_q[i] - 1'b1;
                cnt_d[i] = CNT_LOAD;
              end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
              end
              if (hp_d[i] == '0) gaya_d[i] = 1'b1;
            end
            if (gaya_d != 2'b00) state_d = OVER;
          end
        end
        OVER:    cnt_d = '0;
        default: ;
      endcase
    end
  end

  assign tank1gaya = gaya_q[0];
  assign tank2gaya = gaya_q[1];
  assign health1   = hp_q[0];
  assign health2   = hp_q[1];
  assign invuln1   = (cnt_q[0] != '0);
  assign invuln2   = (cnt_q[1] != '0);

`ifdef SCORE_TRACK_EN
  logic score_edge;
  assign score_edge = (state_q == ACTIVE) && (state_d == OVER);

  // A player scores only when the opponent alone died; a double kill scores neither.
  always_ff @(posedge fsm_clock) begin
    if (!reset_n) begin
      score1 <= 4'd0;
      score2 <= 4'd0;
    end else if (score_edge) begin
      if (gaya_d == 2'b10 && score1 < 4'd9) score1 <= score1 + 4'd1;
      if (gaya_d == 2'b01 && score2 < 4'd9) score2 <= score2 + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tank_hit_tracker.sv
// tb/tb_tank_hit_tracker.sv - directed and randomized checks of tank_hit_tracker against a frame-level model
module tb_tank_hit_tracker;

  logic       fsm_clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       game_on = 1'b0;
  logic       bullet_hit1 = 1'b0, bullet_hit2 = 1'b0;
  logic       mine_hit1 = 1'b0, mine_hit2 = 1'b0;
  logic       tank1gaya, tank2gaya;
  logic [1:0] health1, health2;
  logic       invuln1, invuln2;
`ifdef SCORE_TRACK_EN
  logic [3:0] score1, score2;
`endif

  int passed = 0;
  int total  = 0;

  // Model: round phase 0=not running, 1=playing, 2=someone died.
  int m_hp[2];
  int m_inv[2];
  int m_score[2];
  bit m_dead[2];
  int m_phase;
  bit m_prev_on;

  tank_hit_tracker dut (
    .fsm_clock  (fsm_clock),
    .reset_n    (reset_n),
    .game_on    (game_on),
    .bullet_hit1(bullet_hit1),
    .bullet_hit2(bullet_hit2),
    .mine_hit1  (mine_hit1),
    .mine_hit2  (mine_hit2),
    .tank1gaya  (tank1gaya),
    .tank2gaya  (tank2gaya),
    .health1    (health1),
    .health2    (health2),
    .invuln1    (invuln1),
    .invuln2    (invuln2)
`ifdef SCORE_TRACK_EN
    ,
    .score1     (score1),
    .score2     (score2)
`endif
  );

  always #5 fsm_clock = ~fsm_clock;

  task automatic model_reset();
    m_hp = '{3, 3};
    m_inv = '{0, 0};
    m_dead = '{0, 0};
    m_score = '{0, 0};
    m_phase = 0;
    m_prev_on = 0;
  endtask

  task automatic model_step();
    bit b[2];
    bit m[2];
    b = '{bullet_hit1, bullet_hit2};
    m = '{mine_hit1, mine_hit2};
    if (game_on && !m_prev_on) begin
      m_phase = 1;
      m_hp = '{3, 3};
      m_inv = '{0, 0};
      m_dead = '{0, 0};
    end else if (m_phase == 1) begin
      if (!game_on) begin
        m_phase = 0;
        m_inv = '{0, 0};
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (m[i]) m_hp[i] = 0;
          else if (b[i] && m_inv[i] == 0) begin
            m_hp[i] = (m_hp[i] > 0) ? m_hp[i] - 1 : 0;
            m_inv[i] = 30;
          end else if (m_inv[i] > 0) m_inv[i]--;
          if (m_hp[i] == 0) m_dead[i] = 1;
        end
        if (m_dead[0] || m_dead[1]) begin
          m_phase = 2;
          if (m_dead[1] && !m_dead[0] && m_score[0] < 9) m_score[0]++;
          if (m_dead[0] && !m_dead[1] && m_score[1] < 9) m_score[1]++;
        end
      end
    end else if (m_phase == 2) begin
      m_inv = '{0, 0};
    end
    m_prev_on = game_on;
  endtask

  task automatic tick(input logic on, input logic b1, input logic b2, input logic m1, input logic m2);
    game_on = on;
    bullet_hit1 = b1;
    bullet_hit2 = b2;
    mine_hit1 = m1;
    mine_hit2 = m2;
    @(posedge fsm_clock);
    if (!reset_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    total++;
    if ({health1, health2} !== {2'd3, 2'd3})
      $display("FAIL reset_health got %0d/%0d want 3/3", health1, health2);
    else passed++;
    total++;
    if ({tank1gaya, tank2gaya, invuln1, invuln2} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {tank1gaya, tank2gaya, invuln1, invuln2});
    else passed++;
    tick(1, 0, 0, 0, 0);
    total++;
    if ({health1, health2, tank1gaya, tank2gaya} !== {2'd3, 2'd3, 2'b00})
      $display("FAIL round_start got hp %0d/%0d gaya %b%b want 3/3 00", health1, health2, tank1gaya, tank2gaya);
    else passed++;
  endtask

  task automatic test_bullet_invuln();
    tick(1, 1, 0, 0, 0);
    total++;
    if ({health1, invuln1, health2} !== {2'd2, 1'b1, 2'd3})
      $display("FAIL first_hit got hp1 %0d inv1 %b hp2 %0d want 2 1 3", health1, invuln1, health2);
    else passed++;
    idle(9);
    tick(1, 1, 0, 0, 0);
    total++;
    if (health1 !== 2'd2) $display("FAIL hit_during_invuln got %0d want 2", health1);
    else passed++;
    idle(19);
    total++;
    if (invuln1 !== 1'b1) $display("FAIL invuln_last_frame got %b want 1", invuln1);
    else passed++;
    idle(1);
    total++;
    if (invuln1 !== 1'b0) $display("FAIL invuln_expired got %b want 0", invuln1);
    else passed++;
  endtask

  task automatic test_kill_by_bullets();
    tick(1, 1, 0, 0, 0);
    idle(30);
    tick(1, 1, 0, 0, 0);
    total++;
    if ({health1, tank1gaya, tank2gaya} !== {2'd0, 1'b1, 1'b0})
      $display("FAIL bullet_kill got hp1 %0d gaya %b%b want 0 10", health1, tank1gaya, tank2gaya);
    else passed++;
    tick(1, 0, 1, 0, 0);
    total++;
    if ({health2, tank2gaya} !== {2'd3, 1'b0})
      $display("FAIL over_ignores_hit got hp2 %0d gaya2 %b want 3 0", health2, tank2gaya);
    else passed++;
    total++;
    if ({tank1gaya, invuln1} !== 2'b10)
      $display("FAIL over_frozen got gaya1 %b inv1 %b want 1 0", tank1gaya, invuln1);
    else passed++;
  endtask

  task automatic test_mine();
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    total++;
    if ({health1, health2, tank1gaya} !== {2'd3, 2'd3, 1'b0})
      $display("FAIL restart_clears got hp %0d/%0d gaya1 %b want 3/3 0", health1, health2, tank1gaya);
    else passed++;
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 1);
    total++;
    if ({health2, tank2gaya} !== {2'd0, 1'b1})
      $display("FAIL mine_through_invuln got hp2 %0d gaya2 %b want 0 1", health2, tank2gaya);
    else passed++;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    total++;
    if (tank2gaya !== 1'b1) $display("FAIL gaya_held_offscreen got %b want 1", tank2gaya);
    else passed++;
    tick(1, 0, 0, 0, 0);
    total++;
    if ({tank2gaya, health2} !== {1'b0, 2'd3})
      $display("FAIL gaya_cleared got gaya2 %b hp2 %0d want 0 3", tank2gaya, health2);
    else passed++;
  endtask

  task automatic test_double_kill();
    tick(1, 1, 0, 0, 0);
    idle(30);
    tick(1, 1, 0, 0, 0);
    idle(30);
    tick(1, 1, 0, 0, 1);
    total++;
    if ({tank1gaya, tank2gaya, health1, health2} !== {2'b11, 2'd0, 2'd0})
      $display("FAIL double_kill got gaya %b%b hp %0d/%0d want 11 0/0", tank1gaya, tank2gaya, health1, health2);
    else passed++;
`ifdef SCORE_TRACK_EN
    total++;
    if ({score1, score2} !== {4'(m_score[0]), 4'(m_score[1])})
      $display("FAIL double_kill_score got %0d/%0d want %0d/%0d", score1, score2, m_score[0], m_score[1]);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid_round();
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    idle(30);
    tick(1, 1, 0, 0, 0);
    reset_n = 1'b0;
    tick(0, 1, 1, 1, 1);
    reset_n = 1'b1;
    total++;
    if ({health1, health2, tank1gaya, tank2gaya, invuln1, invuln2} !== {2'd3, 2'd3, 4'b0000})
      $display("FAIL mid_round_reset got hp %0d/%0d flags %b%b%b%b want 3/3 0000",
               health1, health2, tank1gaya, tank2gaya, invuln1, invuln2);
    else passed++;
    for (int k = 0; k < 3; k++) tick(0, 1, 1, 1, 1);
    total++;
    if ({health1, health2, tank1gaya, tank2gaya} !== {2'd3, 2'd3, 2'b00})
      $display("FAIL idle_ignores_hits got hp %0d/%0d gaya %b%b want 3/3 00", health1, health2, tank1gaya, tank2gaya);
    else passed++;
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    total++;
    if (health1 !== 2'd2) $display("FAIL hit_after_restart got %0d want 2", health1);
    else passed++;
  endtask

  task automatic test_random();
    logic on;
    on = game_on;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(79) == 0) on = ~on;
      tick(on, $urandom_range(19) == 0, $urandom_range(19) == 0,
           $urandom_range(149) == 0, $urandom_range(149) == 0);
      total++;
      if ({health1, health2, tank1gaya, tank2gaya, invuln1, invuln2} !==
          {2'(m_hp[0]), 2'(m_hp[1]), m_dead[0], m_dead[1], m_inv[0] != 0, m_inv[1] != 0})
        $display("FAIL random_cycle_%0d got hp %0d/%0d gaya %b%b inv %b%b want %0d/%0d %b%b %b%b",
                 n, health1, health2, tank1gaya, tank2gaya, invuln1, invuln2,
                 m_hp[0], m_hp[1], m_dead[0], m_dead[1], m_inv[0] != 0, m_inv[1] != 0);
      else passed++;
`ifdef SCORE_TRACK_EN
      total++;
      if ({score1, score2} !== {4'(m_score[0]), 4'(m_score[1])})
        $display("FAIL random_score_%0d got %0d/%0d want %0d/%0d", n, score1, score2, m_score[0], m_score[1]);
      else passed++;
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bullet_invuln();
    test_kill_by_bullets();
    test_mine();
    test_double_kill();
    test_reset_mid_round();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
